// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller and the datapath
// that consumes its per-stage control bundle.
package pipe_ctrl_pkg;

    // Run/halt lifecycle states of the sequencer.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        MEM_WAIT = 3'd2,
        DRAIN    = 3'd3,
        HALTED   = 3'd4
    } seq_state_t;

    // Per-stage write-enable / flush / bubble controls, one bit per field.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_bubble;
        logic ex_mem_we;
        logic mem_wb_bubble;
    } stage_ctrl_t;

    // Pipeline held empty (IDLE / HALTED).
    localparam stage_ctrl_t CTRL_EMPTY  = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                           id_ex_we: 1'b0, id_ex_bubble: 1'b1, ex_mem_we: 1'b0,
                                           mem_wb_bubble: 1'b1};
    // Normal flow: every register advances.
    localparam stage_ctrl_t CTRL_FLOW   = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                           id_ex_we: 1'b1, id_ex_bubble: 1'b0, ex_mem_we: 1'b1,
                                           mem_wb_bubble: 1'b0};
    // Memory wait: everything frozen, a NOP is fed into WB.
    localparam stage_ctrl_t CTRL_FROZEN = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                           id_ex_we: 1'b0, id_ex_bubble: 1'b0, ex_mem_we: 1'b0,
                                           mem_wb_bubble: 1'b1};
    // Halt / drain: PC frozen, front end squashed, back end keeps retiring.
    localparam stage_ctrl_t CTRL_DRAIN  = '{pc_we: 1'b0, if_id_we: 1'b1, if_id_flush: 1'b1,
                                           id_ex_we: 1'b1, id_ex_bubble: 1'b1, ex_mem_we: 1'b1,
                                           mem_wb_bubble: 1'b0};
    // Taken branch: redirect PC, squash IF/ID and ID/EX.
    localparam stage_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                           id_ex_we: 1'b1, id_ex_bubble: 1'b1, ex_mem_we: 1'b1,
                                           mem_wb_bubble: 1'b0};
    // Load-use: hold PC and IF/ID, insert a bubble into ID/EX.
    localparam stage_ctrl_t CTRL_STALL  = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                           id_ex_we: 1'b1, id_ex_bubble: 1'b1, ex_mem_we: 1'b1,
                                           mem_wb_bubble: 1'b0};

endpackage

// File: rtl/pipeline_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones, clear on demand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_seq_ctrl.sv
// Pipeline sequencing controller: merges memory waits, halt, branch redirects
// and load-use stalls into per-stage controls, owns run/halt, counts events.
//
// Data-memory handshake: dmem_req marks an access in MEM this cycle and
// dmem_ready marks its completion in the same cycle; a cycle with dmem_req
// high and dmem_ready low is a wait cycle and freezes the whole pipeline.
module pipeline_seq_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             mem_wb_bubble,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt,
    output seq_state_t       state_dbg
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    seq_state_t    state, state_n;
    logic [DW-1:0] drain_cnt, drain_n;
    logic          halt_pend, pend_n;
    stage_ctrl_t   ctrl;
    logic          mem_wait;
    logic          rr_halt, rr_branch, rr_stall;
    stage_ctrl_t   rr_ctrl;
    logic          clr_cnt, inc_stall, inc_flush, inc_wait;

    assign mem_wait = dmem_req && !dmem_ready;

    // Priority decode of the non-wait RUN rules (halt > branch > load-use).
    always_comb begin
        rr_halt   = halt_req || halt_pend;
        rr_branch = !rr_halt && branch_taken;
        rr_stall  = !rr_halt && !branch_taken && load_use_stall;
        rr_ctrl   = CTRL_FLOW;
        if (rr_halt) begin
            rr_ctrl = CTRL_DRAIN;
        end else if (rr_branch) begin
            rr_ctrl = CTRL_BRANCH;
        end else if (rr_stall) begin
            rr_ctrl = CTRL_STALL;
        end
    end

    // Next-state, Mealy control outputs and counter strobes.
    always_comb begin
        state_n   = state;
        drain_n   = drain_cnt;
        pend_n    = halt_pend;
        ctrl      = CTRL_EMPTY;
        clr_cnt   = 1'b0;
        inc_stall = 1'b0;
        inc_flush = 1'b0;
        inc_wait  = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_n = RUN;
                    clr_cnt = 1'b1;
                end
            end
            RUN, MEM_WAIT: begin
                // In MEM_WAIT only ready matters; the request is already known.
                if ((state == RUN) ? mem_wait : !dmem_ready) begin
                    ctrl     = CTRL_FROZEN;
                    state_n  = MEM_WAIT;
                    inc_wait = 1'b1;
                    // A halt arriving while frozen must not be lost.
                    if (halt_req) begin
                        pend_n = 1'b1;
                    end
                end else begin
                    ctrl      = rr_ctrl;
                    inc_flush = rr_branch;
                    inc_stall = rr_stall;
                    if (rr_halt) begin
                        state_n = DRAIN;
                        drain_n = DRAIN_LOAD;
                        pend_n  = 1'b0;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            DRAIN: begin
                if (mem_wait) begin
                    ctrl     = CTRL_FROZEN;
                    inc_wait = 1'b1;
                end else begin
                    ctrl = CTRL_DRAIN;
                    if (drain_cnt == '0) begin
                        state_n = HALTED;
                    end else begin
                        drain_n = drain_cnt - DW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, drain counter and pending-halt registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            halt_pend <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_n;
            halt_pend <= pend_n;
        end
    end

    assign pc_we         = ctrl.pc_we;
    assign if_id_we      = ctrl.if_id_we;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_we      = ctrl.id_ex_we;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_we     = ctrl.ex_mem_we;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign busy          = (state == RUN) || (state == MEM_WAIT) || (state == DRAIN);
    assign done          = (state == HALTED);
    assign state_dbg     = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (reset),
        .clr   (clr_cnt),
        .inc   (inc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (reset),
        .clr   (clr_cnt),
        .inc   (inc_flush),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk   (clk),
        .rst   (reset),
        .clr   (clr_cnt),
        .inc   (inc_wait),
        .count (memwait_cnt)
    );

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// Directed bench for pipeline_seq_ctrl: a 16-bit-counter instance and a
// 4-bit-counter instance share all inputs.
module tb_pipeline_seq_ctrl;
    import pipe_ctrl_pkg::*;

    // Expected control vectors {pc_we, if_id_we, if_id_flush, id_ex_we,
    // id_ex_bubble, ex_mem_we, mem_wb_bubble}.
    localparam logic [6:0] E_IDLE   = 7'b0010101;
    localparam logic [6:0] E_RUN    = 7'b1101010;
    localparam logic [6:0] E_WAIT   = 7'b0000001;
    localparam logic [6:0] E_DRAIN  = 7'b0111110;
    localparam logic [6:0] E_BRANCH = 7'b1111110;
    localparam logic [6:0] E_STALL  = 7'b0001110;

    logic clk = 1'b0;
    logic reset, start, load_use_stall, branch_taken, dmem_req, dmem_ready, halt_req;

    logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble;
    logic        busy, done;
    logic [15:0] stall_cnt, flush_cnt, memwait_cnt;
    seq_state_t  state_dbg;

    logic        p4_pc_we, p4_if_id_we, p4_if_id_flush, p4_id_ex_we, p4_id_ex_bubble;
    logic        p4_ex_mem_we, p4_mem_wb_bubble, p4_busy, p4_done;
    logic [3:0]  p4_stall_cnt, p4_flush_cnt, p4_memwait_cnt;
    seq_state_t  p4_state_dbg;

    logic [6:0] outs;
    assign outs = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble};

    int total = 0;
    int bad   = 0;

    // Clock and DUTs.
    always #5 clk = ~clk;

    pipeline_seq_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .load_use_stall(load_use_stall),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we),
        .mem_wb_bubble(mem_wb_bubble), .busy(busy), .done(done), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt), .state_dbg(state_dbg)
    );

    pipeline_seq_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .load_use_stall(load_use_stall),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .pc_we(p4_pc_we), .if_id_we(p4_if_id_we),
        .if_id_flush(p4_if_id_flush), .id_ex_we(p4_id_ex_we), .id_ex_bubble(p4_id_ex_bubble),
        .ex_mem_we(p4_ex_mem_we), .mem_wb_bubble(p4_mem_wb_bubble), .busy(p4_busy),
        .done(p4_done), .stall_cnt(p4_stall_cnt), .flush_cnt(p4_flush_cnt),
        .memwait_cnt(p4_memwait_cnt), .state_dbg(p4_state_dbg)
    );

    // Comparison point: counts every check and every failure.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load_use_stall = 1'b0; branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
        #2;
        chk("reset_outs", 32'(outs), 32'(E_IDLE));
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_state", 32'(state_dbg), 32'(IDLE));
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("idle_outs", 32'(outs), 32'(E_IDLE));
        chk("idle_done", 32'(done), 32'd0);

        // Start: IDLE outputs during the start cycle, RUN afterwards.
        start = 1'b1;
        #1;
        chk("start_cycle_outs", 32'(outs), 32'(E_IDLE));
        tick();
        start = 1'b0;
        #1;
        chk("run_state", 32'(state_dbg), 32'(RUN));
        chk("run_outs", 32'(outs), 32'(E_RUN));
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_stall_cnt0", 32'(stall_cnt), 32'd0);
        chk("run_flush_cnt0", 32'(flush_cnt), 32'd0);
        chk("run_memwait_cnt0", 32'(memwait_cnt), 32'd0);

        // Load-use stall, then branch wins over the still-asserted stall.
        load_use_stall = 1'b1;
        #1;
        chk("stall_outs", 32'(outs), 32'(E_STALL));
        tick();
        branch_taken = 1'b1;
        #1;
        chk("branch_over_stall_outs", 32'(outs), 32'(E_BRANCH));
        tick();
        load_use_stall = 1'b0;
        branch_taken = 1'b0;
        #1;
        chk("stall_cnt_1", 32'(stall_cnt), 32'd1);
        chk("flush_cnt_1", 32'(flush_cnt), 32'd1);
        chk("after_branch_outs", 32'(outs), 32'(E_RUN));

        // Three wait cycles, then ready together with a load-use stall.
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wait_outs_%0d", i), 32'(outs), 32'(E_WAIT));
            tick();
        end
        chk("memwait_cnt_3", 32'(memwait_cnt), 32'd3);
        chk("memwait_state", 32'(state_dbg), 32'(MEM_WAIT));
        dmem_ready = 1'b1;
        load_use_stall = 1'b1;
        #1;
        chk("ready_stall_outs", 32'(outs), 32'(E_STALL));
        tick();
        dmem_req = 1'b0;
        dmem_ready = 1'b0;
        load_use_stall = 1'b0;
        #1;
        chk("back_to_run_state", 32'(state_dbg), 32'(RUN));
        chk("stall_cnt_2", 32'(stall_cnt), 32'd2);
        chk("memwait_cnt_still_3", 32'(memwait_cnt), 32'd3);
        chk("back_to_run_outs", 32'(outs), 32'(E_RUN));

        // Halt pulsed while in MEM_WAIT; acted upon once ready arrives.
        dmem_req = 1'b1;
        #1;
        chk("wait2_outs", 32'(outs), 32'(E_WAIT));
        tick();
        halt_req = 1'b1;
        #1;
        chk("halt_in_wait_outs", 32'(outs), 32'(E_WAIT));
        tick();
        halt_req = 1'b0;
        dmem_ready = 1'b1;
        #1;
        chk("pending_halt_outs", 32'(outs), 32'(E_DRAIN));
        chk("pending_halt_state", 32'(state_dbg), 32'(MEM_WAIT));
        tick();
        dmem_req = 1'b0;
        dmem_ready = 1'b0;
        begin
            int n = 0;
            while (!done && n < 10) begin
                #1;
                chk($sformatf("drain_outs_%0d", n), 32'(outs), 32'(E_DRAIN));
                chk($sformatf("drain_state_%0d", n), 32'(state_dbg), 32'(DRAIN));
                tick();
                n++;
            end
            chk("drain_length", 32'(n), 32'd3);
        end
        chk("halted_done", 32'(done), 32'd1);
        chk("halted_busy", 32'(busy), 32'd0);
        chk("halted_outs", 32'(outs), 32'(E_IDLE));
        chk("halted_state", 32'(state_dbg), 32'(HALTED));
        chk("memwait_cnt_5", 32'(memwait_cnt), 32'd5);

        // Restart from HALTED clears all counters.
        start = 1'b1;
        #1;
        tick();
        start = 1'b0;
        #1;
        chk("restart_state", 32'(state_dbg), 32'(RUN));
        chk("restart_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("restart_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("restart_memwait_cnt", 32'(memwait_cnt), 32'd0);
        chk("restart_stall_cnt4", 32'(p4_stall_cnt), 32'd0);

        // 20 stall cycles: 4-bit counter saturates at 15.
        load_use_stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (i == 0 || i == 19) begin
                chk($sformatf("sat_stall_outs_%0d", i), 32'(outs), 32'(E_STALL));
            end
            tick();
        end
        load_use_stall = 1'b0;
        #1;
        chk("sat_cnt4", 32'(p4_stall_cnt), 32'd15);
        chk("sat_cnt16", 32'(stall_cnt), 32'd20);

        // Start while running is ignored.
        start = 1'b1;
        #1;
        chk("start_in_run_outs", 32'(outs), 32'(E_RUN));
        tick();
        start = 1'b0;
        #1;
        chk("start_in_run_state", 32'(state_dbg), 32'(RUN));
        chk("start_in_run_cnt16", 32'(stall_cnt), 32'd20);
        chk("start_in_run_cnt4", 32'(p4_stall_cnt), 32'd15);

        // Direct halt, then reset in the middle of DRAIN.
        halt_req = 1'b1;
        #1;
        chk("direct_halt_outs", 32'(outs), 32'(E_DRAIN));
        tick();
        halt_req = 1'b0;
        #1;
        chk("direct_drain_state", 32'(state_dbg), 32'(DRAIN));
        tick();
        reset = 1'b1;
        #1;
        chk("async_reset_outs", 32'(outs), 32'(E_IDLE));
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_state", 32'(state_dbg), 32'(IDLE));
        chk("async_reset_cnt", 32'(stall_cnt), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        tick();
        chk("post_reset_idle", 32'(state_dbg), 32'(IDLE));
        chk("post_reset_done", 32'(done), 32'd0);
        start = 1'b1;
        #1;
        tick();
        start = 1'b0;
        #1;
        chk("rerun_state", 32'(state_dbg), 32'(RUN));
        chk("rerun_outs", 32'(outs), 32'(E_RUN));
        load_use_stall = 1'b1;
        #1;
        tick();
        load_use_stall = 1'b0;
        #1;
        chk("rerun_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("rerun_outs2", 32'(outs), 32'(E_RUN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_seq_ctrl.md
# pipeline_seq_ctrl

Central pipeline sequencing controller for the 5-stage core. It merges the load-use stall request from the hazard unit, taken-branch redirects, multi-cycle data-memory waits and program halt into one consistent set of per-stage write-enable, flush and bubble controls. It also owns the run/halt lifecycle and three saturating performance counters. It sits beside the hazard unit in ID and drives every pipeline register plus the PC.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles spent emptying the pipeline after a halt request.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: leaves IDLE or HALTED and begins execution.
- `load_use_stall`, input, 1: hazard-unit stall request.
- `branch_taken`, input, 1: the branch in EX resolved as taken.
- `dmem_req`, input, 1: a load or store is in MEM this cycle.
- `dmem_ready`, input, 1: data memory completes the access this cycle.
- `halt_req`, input, 1: a halt instruction has reached EX.
- `pc_we`, output, 1: PC write enable.
- `if_id_we`, output, 1: IF/ID register write enable.
- `if_id_flush`, output, 1: IF/ID register loads a NOP.
- `id_ex_we`, output, 1: ID/EX register write enable.
- `id_ex_bubble`, output, 1: ID/EX register loads a NOP.
- `ex_mem_we`, output, 1: EX/MEM register write enable.
- `mem_wb_bubble`, output, 1: MEM/WB register loads a NOP.
- `busy`, output, 1: high in RUN, MEM_WAIT and DRAIN.
- `done`, output, 1: high only in HALTED.
- `stall_cnt`, output, CNT_W: count of load-use stall cycles.
- `flush_cnt`, output, CNT_W: count of branch flushes.
- `memwait_cnt`, output, CNT_W: count of memory-wait cycles.

## Operation
States: IDLE, RUN, MEM_WAIT, DRAIN, HALTED.

Reset forces IDLE. It clears all counters, the drain counter and `halt_pend`.

IDLE and HALTED hold the pipeline empty:
- All `*_we` = 0; `if_id_flush`, `id_ex_bubble`, `mem_wb_bubble` = 1; `busy` = 0.
- `done` = 1 only in HALTED.
- On `start`: go to RUN and clear all three counters.

RUN evaluates conditions in strict priority order. The first match wins.
1. **Memory wait** (`dmem_req && !dmem_ready`):
   - All `*_we` = 0; `mem_wb_bubble` = 1; `if_id_flush` and `id_ex_bubble` = 0.
   - Next state MEM_WAIT. `memwait_cnt` increments.
2. **Halt** (`halt_req || halt_pend`):
   - `pc_we` = 0; `if_id_flush` = 1; `id_ex_bubble` = 1; `ex_mem_we` = 1.
   - Next state DRAIN. Drain counter loads `DRAIN_CYCLES-1`. `halt_pend` clears.
3. **Branch redirect** (`branch_taken`):
   - `pc_we` = 1; `if_id_flush` = 1; `id_ex_bubble` = 1; `ex_mem_we` = 1.
   - `flush_cnt` increments.
4. **Load-use stall** (`load_use_stall`):
   - `pc_we` = 0; `if_id_we` = 0; `id_ex_bubble` = 1; `ex_mem_we` = 1.
   - `stall_cnt` increments.
5. **Otherwise:** all `*_we` = 1; all flush and bubble outputs = 0.

Branch beats load-use because the stalled instruction is squashed anyway.

MEM_WAIT:
- While `!dmem_ready`: outputs are frozen exactly as in rule 1, and `memwait_cnt` increments.
- A `halt_req` seen here sets `halt_pend`.
- When `dmem_ready` = 1: outputs equal RUN rules 2–5 applied that same cycle, with the next state those rules select (RUN or DRAIN).

DRAIN:
- `pc_we` = 0; `if_id_flush` = 1; `id_ex_bubble` = 1; `ex_mem_we` = 1; `if_id_we` and `id_ex_we` = 1.
- A memory wait inside DRAIN freezes the pipeline as in rule 1 and holds the drain counter.
- When the counter is 0 and no wait is active: go to HALTED.

Counters saturate at all-ones and never wrap. `start` outside IDLE and HALTED is ignored.

## Timing
- Control outputs are Mealy: combinational from the current state and this cycle's inputs, with zero latency. Stage registers use them at the same edge.
- State, the drain counter, `halt_pend` and the performance counters are registered and update at the edge that ends the qualifying cycle.
- `done` rises in the first HALTED cycle. Halt request to `done` takes `DRAIN_CYCLES`+1 cycles when no memory waits occur.
- Reset mid-operation (any state, any cycle) immediately forces IDLE outputs asynchronously. It discards `halt_pend` and any in-progress drain.

## Structure
- Shared package `pipe_ctrl_pkg` holds the state enum `seq_state_t` and a packed struct `stage_ctrl_t` bundling the seven per-stage control bits. This lets the datapath and this block share one definition.
- One natural sub-module, `sat_counter`, parameterised by width, with a clear input and an increment-enable input. It is instantiated three times.
- The FSM, drain counter and priority logic live in the top module.

## Test plan
- Reset, then `start`: IDLE outputs hold with `done`=0; one cycle after `start`, all `*_we`=1, state is RUN and the counters read 0.
- `load_use_stall` high for 2 cycles together with `branch_taken` in the second cycle: cycle 1 gives `pc_we`=0, `id_ex_bubble`=1; cycle 2 gives `pc_we`=1, `if_id_flush`=1. Finally `stall_cnt`=1 and `flush_cnt`=1.
- `dmem_req`=1 with `dmem_ready` low for 3 cycles, then high with `load_use_stall`=1: 3 fully frozen cycles, then the stall pattern, then RUN. `memwait_cnt`=3.
- `halt_req` pulsed during MEM_WAIT, `DRAIN_CYCLES`=3: `halt_pend` set; after ready, exactly 3 DRAIN cycles, then `done`=1 and `busy`=0.
- `CNT_W`=4 with 20 consecutive stall cycles: `stall_cnt` stops at 15.
- Reset asserted in the middle of DRAIN: outputs drop to IDLE values without waiting for a clock edge, and a later `start` runs normally.
